// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch and data requesters onto one fixed-latency,
// single-ported word memory and returns read data with a one-cycle done pulse.
module mem_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MEM_LAT  = 1,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic              d_err,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic       GNT_FETCH = 1'b0;
  localparam logic       GNT_DATA  = 1'b1;
  localparam logic [3:0] CNT_LOAD  = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              sel_data;
  logic [31:0]       sel_addr;
  logic              unused_addr_hi;

  // last_gnt also identifies the owner of the access in flight.
  always_comb begin
    sel_data = 1'b0;
    if (d_req && !if_req) begin
      sel_data = 1'b1;
    end else if (d_req && if_req) begin
      sel_data = (ARB_MODE != 0) || (last_gnt_q == GNT_FETCH);
    end
    sel_addr = sel_data ? d_addr : if_addr;
  end

  assign unused_addr_hi = ^sel_addr[31:ADDR_W+2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          last_gnt_d = sel_data;
          addr_d     = sel_addr[ADDR_W+1:2];
          we_d       = sel_data && d_we;
          wdata_d    = d_wdata;
          err_d      = (sel_addr[1:0] != 2'b00);
          state_d    = err_d ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // mem_rdata is only trusted on the exact cycle the latency expires.
        if (cnt_q == 4'd0) begin
          rdata_d = mem_rdata;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    mem_en    = (state_q == S_ACCESS);
    mem_we    = mem_en && we_q;
    mem_addr  = mem_en ? addr_q : '0;
    mem_wdata = mem_en ? wdata_q : '0;
    if_done   = (state_q == S_DONE) && (last_gnt_q == GNT_FETCH);
    d_done    = (state_q == S_DONE) && (last_gnt_q == GNT_DATA);
    if_err    = if_done && err_q;
    d_err     = d_done && err_q;
    rdata     = rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      last_gnt_q <= GNT_DATA;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Request payload; only observed through state-gated outputs.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance 0 is MEM_LAT=1 round-robin, instance 1 is MEM_LAT=4 fixed priority.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;

  logic [1:0]        if_req, d_req, d_we;
  logic [1:0]        if_done, if_err, d_done, d_err, busy, mem_en, mem_we;
  logic [1:0][31:0]  if_addr, d_addr, d_wdata, rdata, mem_wdata, mem_rdata;
  logic [1:0][9:0]   mem_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 4;
    logic [31:0] mem [0:1023];
    logic [31:0] pend_data;
    int          pend_cnt = 0;

    always @(posedge clk) begin
      if (mem_init) begin
        for (int i = 0; i < 1024; i++)
          mem[i] <= (i == 3) ? 32'h2002000A : (32'h1000_0000 | i);
      end else if (mem_en[g] && mem_we[g]) begin
        mem[mem_addr[g]] <= mem_wdata[g];
      end
      if (mem_en[g] && !mem_we[g]) begin
        pend_data <= mem[mem_addr[g]];
        pend_cnt  <= LAT;
      end else if (pend_cnt > 0) begin
        pend_cnt <= pend_cnt - 1;
      end
    end

    // Garbage everywhere except the one cycle the memory guarantees valid data.
    assign mem_rdata[g] = (pend_cnt == 1) ? pend_data : 32'hBAD0_BAD0;

    mem_port_arbiter #(.ADDR_W(10), .MEM_LAT(LAT), .ARB_MODE(g)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_done   (if_done[g]),
      .if_err    (if_err[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_done    (d_done[g]),
      .d_err     (d_err[g]),
      .rdata     (rdata[g]),
      .busy      (busy[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    if_req = '0; d_req = '0; d_we = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    reset = 1'b0; mem_init = 1'b1;
    #6;
    chk("rst_busy0", 32'(busy[0]), 0);
    chk("rst_busy1", 32'(busy[1]), 0);
    chk("rst_mem_en0", 32'(mem_en[0]), 0);
    chk("rst_mem_addr0", 32'(mem_addr[0]), 0);
    chk("rst_rdata0", rdata[0], 0);
    chk("rst_rdata1", rdata[1], 0);
    chk("rst_done", {28'd0, if_done, d_done}, 0);
    mem_init = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Single fetch on instance 0
    if_req[0] = 1'b1; if_addr[0] = 32'h0C;
    tick();
    chk("fetch_mem_en", 32'(mem_en[0]), 1);
    chk("fetch_mem_addr", 32'(mem_addr[0]), 3);
    chk("fetch_busy", 32'(busy[0]), 1);
    tick();
    chk("fetch_wait_mem_en", 32'(mem_en[0]), 0);
    tick();
    chk("fetch_done", 32'(if_done[0]), 1);
    chk("fetch_err", 32'(if_err[0]), 0);
    chk("fetch_rdata", rdata[0], 32'h2002000A);
    if_req[0] = 1'b0;
    tick();
    chk("fetch_idle_busy", 32'(busy[0]), 0);
    chk("fetch_idle_done", 32'(if_done[0]), 0);

    // Store then load
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h40; d_wdata[0] = 32'hDEADBEEF;
    tick();
    chk("st_mem_en", 32'(mem_en[0]), 1);
    chk("st_mem_we", 32'(mem_we[0]), 1);
    chk("st_mem_addr", 32'(mem_addr[0]), 32'h10);
    chk("st_mem_wdata", mem_wdata[0], 32'hDEADBEEF);
    tick();
    chk("st_done", 32'(d_done[0]), 1);
    chk("st_rdata_kept", rdata[0], 32'h2002000A);
    d_req[0] = 1'b0;
    tick();
    d_req[0] = 1'b1; d_we[0] = 1'b0;
    tick();
    chk("ld_mem_we", 32'(mem_we[0]), 0);
    tick();
    tick();
    chk("ld_done", 32'(d_done[0]), 1);
    chk("ld_rdata", rdata[0], 32'hDEADBEEF);
    d_req[0] = 1'b0;
    tick();

    // Misaligned data access
    d_req[0] = 1'b1; d_addr[0] = 32'h42;
    tick();
    chk("mis_done", 32'(d_done[0]), 1);
    chk("mis_err", 32'(d_err[0]), 1);
    chk("mis_mem_en", 32'(mem_en[0]), 0);
    chk("mis_rdata", rdata[0], 32'hDEADBEEF);
    d_req[0] = 1'b0; d_addr[0] = 32'h40;
    tick();
    chk("mis_after", {30'd0, d_done[0], busy[0]}, 0);

    reset = 1'b0;
    tick();
    reset = 1'b1;

    // Round-robin on a sustained tie, instance 0
    if_req[0] = 1'b1; if_addr[0] = 32'h0C; d_req[0] = 1'b1; d_we[0] = 1'b0;
    tick();
    chk("rr1_addr", 32'(mem_addr[0]), 3);
    tick(); tick();
    chk("rr1_done", {30'd0, if_done[0], d_done[0]}, 2);
    chk("rr1_rdata", rdata[0], 32'h2002000A);
    tick(); tick();
    chk("rr2_addr", 32'(mem_addr[0]), 32'h10);
    tick(); tick();
    chk("rr2_done", {30'd0, if_done[0], d_done[0]}, 1);
    chk("rr2_rdata", rdata[0], 32'hDEADBEEF);
    tick(); tick();
    chk("rr3_addr", 32'(mem_addr[0]), 3);
    tick(); tick();
    chk("rr3_done", {30'd0, if_done[0], d_done[0]}, 2);
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    tick();

    // Fixed priority and MEM_LAT=4, instance 1
    if_req[1] = 1'b1; if_addr[1] = 32'h0C; d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h20;
    tick();
    chk("fp1_mem_en", 32'(mem_en[1]), 1);
    chk("fp1_addr", 32'(mem_addr[1]), 8);
    tick();
    chk("lat_wait_mem_en", 32'(mem_en[1]), 0);
    tick(); tick(); tick();
    chk("lat_t5_done", 32'(d_done[1]), 0);
    chk("lat_t5_rdata", rdata[1], 0);
    tick();
    chk("lat_t6_done", {30'd0, if_done[1], d_done[1]}, 1);
    chk("lat_t6_rdata", rdata[1], 32'h1000_0008);
    tick(); tick();
    chk("fp2_addr", 32'(mem_addr[1]), 8);
    tick(); tick(); tick(); tick(); tick();
    chk("fp2_done", {30'd0, if_done[1], d_done[1]}, 1);
    d_req[1] = 1'b0;
    tick(); tick();
    chk("fp3_addr", 32'(mem_addr[1]), 3);
    tick(); tick(); tick(); tick(); tick();
    chk("fp3_done", {30'd0, if_done[1], d_done[1]}, 2);
    chk("fp3_rdata", rdata[1], 32'h2002000A);
    if_req[1] = 1'b0;
    tick();

    // Reset during WAIT of a read, instance 1
    if_req[1] = 1'b1; if_addr[1] = 32'h0C;
    tick(); tick(); tick();
    chk("mid_pre_busy", 32'(busy[1]), 1);
    reset = 1'b0; if_req[1] = 1'b0;
    #1;
    chk("mid_busy", 32'(busy[1]), 0);
    chk("mid_mem_en", 32'(mem_en[1]), 0);
    chk("mid_done", 32'(if_done[1]), 0);
    chk("mid_rdata", rdata[1], 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_quiet", {30'd0, if_done[1], busy[1]}, 0);
    end
    if_req[1] = 1'b1;
    tick();
    chk("rec_mem_en", 32'(mem_en[1]), 1);
    tick(); tick(); tick(); tick();
    chk("rec_t5_done", 32'(if_done[1]), 0);
    tick();
    chk("rec_done", 32'(if_done[1]), 1);
    chk("rec_rdata", rdata[1], 32'h2002000A);
    if_req[1] = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported word memory between the multi-cycle core's instruction-fetch requester and its data (load/store) requester.
- Arbitrates between the two requesters, sequences each access through a fixed-latency memory port, and returns read data with a one-cycle done pulse.
- Sits between the core's fetch/IorD path and the unified memory array; it replaces the separate instruction and data arrays.

Parameters:
- ADDR_W, 10, word-address width of memory (1024 words); mem_addr = byte_addr[ADDR_W+1:2]
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..15
- ARB_MODE, 0, 0 = round-robin on simultaneous requests, 1 = fixed priority with data over fetch

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0); one clock domain only
- if_req  input  1  fetch request; held high until if_done
- if_addr  input  32  fetch byte address
- if_done  output  1  one-cycle pulse: fetch access complete
- if_err  output  1  valid with if_done: misaligned address, no memory access made
- d_req  input  1  data request; held high until d_done
- d_we  input  1  1 = store, 0 = load; sampled with d_req
- d_addr  input  32  data byte address
- d_wdata  input  32  store data
- d_done  output  1  one-cycle pulse: data access complete
- d_err  output  1  valid with d_done: misaligned address
- rdata  output  32  read data; valid in the cycle of if_done or d_done (reads only)
- busy  output  1  high in every state except IDLE
- mem_en  output  1  memory access strobe, exactly one cycle per access
- mem_we  output  1  write enable, qualified by mem_en
- mem_addr  output  ADDR_W  word address
- mem_wdata  output  32  write data
- mem_rdata  input  32  memory read data, valid MEM_LAT cycles after the mem_en cycle

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; all outputs are 0; rdata = 0.
  - Latency counter is 0. last_gnt = DATA, so fetch wins the first tie in round-robin mode.
  - Reset during any state abandons the access in flight. mem_en and mem_we fall immediately. No done pulse is issued for the abandoned access.
- States:
  - IDLE: if neither request is high, stay in IDLE. Otherwise select a winner and latch its addr, we (fetch we = 0) and wdata into internal registers. Record the winner in last_gnt.
    - If latched addr[1:0] != 0, go to DONE with err set.
    - Otherwise go to ACCESS.
  - ACCESS (one cycle): mem_en = 1; mem_addr, mem_we and mem_wdata come from the latched registers.
    - On a write, go to DONE.
    - On a read, load cnt = MEM_LAT-1 and go to WAIT.
  - WAIT: if cnt = 0, capture mem_rdata into rdata and go to DONE. Otherwise decrement cnt.
  - DONE (one cycle): assert the winner's done, and its err if the access was misaligned. Go to IDLE.
- Arbitration, when both requests are high in IDLE:
  - ARB_MODE=0: grant the requester that is not last_gnt.
  - ARB_MODE=1: grant data always.
  - When only one request is high, grant it regardless of mode.
- Latency, measured from the IDLE cycle in which the request is sampled:
  - Read: done in cycle T+MEM_LAT+2.
  - Write: done in T+2.
  - Misaligned access: done in T+1.
  - After DONE there is a mandatory IDLE cycle before the next grant.
- Handshake:
  - The requester holds req, addr, we and wdata stable until its done pulse.
  - The requester drops req in the cycle after done or issues a new request.
  - Arbiter inputs are sampled only in IDLE. A req deasserted mid-access is ignored: the access completes and done still pulses.
- rdata holds its last captured value between reads. Writes and errors leave rdata unchanged.
- The losing requester waits with no timeout. Round-robin bounds its wait to one access.
- Outputs are registered (state-decoded from registered state); there are no combinational paths from inputs to outputs.

Test Plan:
- Single fetch: MEM_LAT=1, mem[3]=0x2002000A, if_req=1, if_addr=0x0C at T → mem_en=1, mem_addr=3 at T+1; if_done=1, rdata=0x2002000A at T+3; busy low at T+4.
- Store then load: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF → mem_we=1, mem_addr=0x10 at T+1, d_done at T+2. Then a load from 0x40 → rdata=0xDEADBEEF.
- Simultaneous requests after reset, ARB_MODE=0: fetch is granted first, data second, fetch third on a sustained tie (alternation). With ARB_MODE=1, data is granted every tie.
- Misaligned access: d_addr=0x42 → d_done=1, d_err=1 at T+1; mem_en never asserts; rdata unchanged.
- Latency sweep: MEM_LAT=4 read → done at T+6; mem_rdata is sampled only on the WAIT cycle with cnt=0. Wrong data driven on earlier cycles must not appear on rdata.
- Reset mid-access: reset=0 during the WAIT of a read → busy, mem_en and done are 0 immediately, no done pulse follows. After release, a new fetch completes normally at nominal latency.
